if_id_queue: RTL and testbench

IF_ID_QUEUE -- requirements
Module: if_id_queue

---
 rtl/if_id_queue.sv | 104 ++++++++++
 tb/tb_if_id_queue.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: circular FIFO of {pc, instruction} pairs between fetch and decode.
// Optional flush statistics output enabled by defining IF_ID_QUEUE_STATS_EN.
module if_id_queue #(
  parameter int unsigned DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [14:0] pc_IF,
  input  logic [31:0] instruction_IF,
  input  logic        valid_IF,
  input  logic        stall_ID,
  input  logic        flush_EXE,
  output logic        pc_write_HZRD,
  output logic [14:0] pc_ID,
  output logic [31:0] instruction_ID,
  output logic        valid_ID
`ifdef IF_ID_QUEUE_STATS_EN
  ,
  output logic [15:0] flush_count
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [46:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;

  // Flow control comes from registered occupancy only, so IF never sees a combinational path.
  assign pc_write_HZRD = (count_q != CntW'(DEPTH));
  assign valid_ID      = (count_q != '0);
  assign push          = valid_IF && pc_write_HZRD && !flush_EXE;
  assign pop           = valid_ID && !stall_ID && !flush_EXE;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_EXE) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; valid_ID masks stale contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {pc_IF, instruction_IF};
  end

  always_comb begin
    pc_ID          = 15'd0;
    instruction_ID = NOP;
    if (valid_ID) begin
      pc_ID          = mem_q[rd_ptr_q][46:32];
      instruction_ID = mem_q[rd_ptr_q][31:0];
    end
  end

`ifdef IF_ID_QUEUE_STATS_EN
  logic [15:0] flush_count_q, flush_count_d;
  logic [16:0] flush_sum;

  // Each flush discards every entry currently held; the total saturates.
  assign flush_sum = {1'b0, flush_count_q} + 17'(count_q);

  always_comb begin
    flush_count_d = flush_count_q;
    if (flush_EXE) flush_count_d = flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) flush_count_q <= '0;
    else          flush_count_q <= flush_count_d;
  end

  assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: queue-based reference model checked every cycle plus directed scenarios.
module tb_if_id_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [14:0] pc_IF;
  logic [31:0] instruction_IF;
  logic        valid_IF, stall_ID, flush_EXE;
  logic        pc_write_HZRD;
  logic [14:0] pc_ID;
  logic [31:0] instruction_ID;
  logic        valid_ID;
`ifdef IF_ID_QUEUE_STATS_EN
  logic [15:0] flush_count;
`endif

  int errors = 0;
  int checks = 0;

  if_id_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pc_IF          (pc_IF),
    .instruction_IF (instruction_IF),
    .valid_IF       (valid_IF),
    .stall_ID       (stall_ID),
    .flush_EXE      (flush_EXE),
    .pc_write_HZRD  (pc_write_HZRD),
    .pc_ID          (pc_ID),
    .instruction_ID (instruction_ID),
    .valid_ID       (valid_ID)
`ifdef IF_ID_QUEUE_STATS_EN
    ,
    .flush_count    (flush_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of {pc, instruction} plus a discarded-entry tally.
  logic [46:0] model_q[$];
  int unsigned model_flushed = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_q.delete();
      model_flushed = 0;
    end else if (flush_EXE) begin
      model_flushed = model_flushed + model_q.size();
      if (model_flushed > 16'hFFFF) model_flushed = 16'hFFFF;
      model_q.delete();
    end else begin
      bit do_pop, do_push;
      do_pop  = (model_q.size() != 0) && !stall_ID;
      do_push = valid_IF && (model_q.size() != DEPTH);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back({pc_IF, instruction_IF});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_compare();
    logic        e_valid;
    logic [14:0] e_pc;
    logic [31:0] e_ins;
    e_valid = (model_q.size() != 0);
    e_pc    = e_valid ? model_q[0][46:32] : 15'd0;
    e_ins   = e_valid ? model_q[0][31:0] : NOP;
    chk("model valid_ID", {31'd0, valid_ID}, {31'd0, e_valid});
    chk("model pc_ID", {17'd0, pc_ID}, {17'd0, e_pc});
    chk("model instruction_ID", instruction_ID, e_ins);
    chk("model pc_write_HZRD", {31'd0, pc_write_HZRD},
        {31'd0, (model_q.size() != DEPTH)});
`ifdef IF_ID_QUEUE_STATS_EN
    chk("model flush_count", {16'd0, flush_count}, model_flushed);
`endif
  endtask

  always @(negedge clk) model_compare();

  function automatic logic [31:0] ins_of(input logic [14:0] pc);
    return 32'hA500_0000 | {17'd0, pc};
  endfunction

  // Drive one cycle of inputs, let an edge happen, and return 1 time unit after it.
  task automatic step(input logic v, input logic [14:0] pc, input logic st, input logic fl);
    valid_IF       = v;
    pc_IF          = pc;
    instruction_IF = ins_of(pc);
    stall_ID       = st;
    flush_EXE      = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    valid_IF = 1'b0; pc_IF = '0; instruction_IF = '0; stall_ID = 1'b0; flush_EXE = 1'b0;
    #3;
    chk("reset valid_ID", {31'd0, valid_ID}, 32'd0);
    chk("reset pc_ID", {17'd0, pc_ID}, 32'd0);
    chk("reset instruction_ID", instruction_ID, 32'h00000013);
    chk("reset pc_write_HZRD", {31'd0, pc_write_HZRD}, 32'd1);
    #4 reset_n = 1'b1;
    @(posedge clk); #1;

    // Fill with decode stalled.
    for (int i = 0; i < 4; i++) step(1'b1, 15'(4 * i), 1'b1, 1'b0);
    chk("full pc_write_HZRD", {31'd0, pc_write_HZRD}, 32'd0);
    chk("full valid_ID", {31'd0, valid_ID}, 32'd1);
    chk("full pc_ID", {17'd0, pc_ID}, 32'd0);
    // Push attempt while full must be ignored.
    step(1'b1, 15'd16, 1'b1, 1'b0);
    chk("full reject pc_ID", {17'd0, pc_ID}, 32'd0);
    chk("full reject pc_write_HZRD", {31'd0, pc_write_HZRD}, 32'd0);

    // Drain in order; the first pop reopens the queue.
    for (int i = 0; i < 4; i++) begin
      chk("drain pc_ID", {17'd0, pc_ID}, 32'(4 * i));
      step(1'b0, 15'd0, 1'b0, 1'b0);
      if (i == 0) chk("pop from full pc_write_HZRD", {31'd0, pc_write_HZRD}, 32'd1);
    end
    chk("drained valid_ID", {31'd0, valid_ID}, 32'd0);
    chk("drained instruction_ID", instruction_ID, 32'h00000013);

    // Streaming: one entry resident, head tracks the previous cycle's input.
    step(1'b1, 15'd100, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 15'(100 + 4 * k), 1'b0, 1'b0);
      chk("stream pc_ID", {17'd0, pc_ID}, 32'(100 + 4 * k));
      chk("stream valid_ID", {31'd0, valid_ID}, 32'd1);
      chk("stream pc_write_HZRD", {31'd0, pc_write_HZRD}, 32'd1);
    end
    step(1'b0, 15'd0, 1'b0, 1'b0);
    chk("stream end valid_ID", {31'd0, valid_ID}, 32'd0);

    // Flush with three entries and a colliding push.
    for (int i = 0; i < 3; i++) step(1'b1, 15'(20 + 4 * i), 1'b1, 1'b0);
    chk("pre-flush pc_ID", {17'd0, pc_ID}, 32'd20);
    step(1'b1, 15'd40, 1'b0, 1'b1);
    chk("flush valid_ID", {31'd0, valid_ID}, 32'd0);
    chk("flush instruction_ID", instruction_ID, 32'h00000013);
    chk("flush pc_write_HZRD", {31'd0, pc_write_HZRD}, 32'd1);
`ifdef IF_ID_QUEUE_STATS_EN
    chk("flush_count after flush", {16'd0, flush_count}, 32'd3);
`endif
    step(1'b1, 15'd44, 1'b1, 1'b0);
    chk("post-flush head pc_ID", {17'd0, pc_ID}, 32'd44);
    step(1'b0, 15'd0, 1'b0, 1'b0);
    chk("post-flush single entry", {31'd0, valid_ID}, 32'd0);

    // Asynchronous reset between edges with two entries.
    step(1'b1, 15'd60, 1'b1, 1'b0);
    step(1'b1, 15'd64, 1'b1, 1'b0);
    valid_IF = 1'b0;
    chk("pre-reset valid_ID", {31'd0, valid_ID}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset valid_ID", {31'd0, valid_ID}, 32'd0);
    chk("async reset pc_write_HZRD", {31'd0, pc_write_HZRD}, 32'd1);
    chk("async reset pc_ID", {17'd0, pc_ID}, 32'd0);
    chk("async reset instruction_ID", instruction_ID, 32'h00000013);
`ifdef IF_ID_QUEUE_STATS_EN
    chk("async reset flush_count", {16'd0, flush_count}, 32'd0);
`endif
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 15'd80, 1'b1, 1'b0);
    chk("post-reset head pc_ID", {17'd0, pc_ID}, 32'd80);
    chk("post-reset instruction_ID", instruction_ID, 32'hA500_0050);
    step(1'b0, 15'd0, 1'b0, 1'b0);
    step(1'b0, 15'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
